lcd_cmd_sequencer: RTL

- Sits between a host command source and LCD_CTRL. Buffers host image-edit commands in a FIFO and issues them to the LCD controller one at a time, respecting its busy/done handshake.
- Pacing rules:
  - Holds off until the initial image load completes.
  - Spaces consecutive commands by a programmable gap.
  - After the Write (cmd 0) command, waits for the frame-dump done and then locks.

---
 rtl/lcd_cmd_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/lcd_cmd_sequencer.sv
// Command sequencer for LCD_CTRL: buffers host edit commands in a FIFO and
// issues them one at a time with load hold-off, inter-command gap and Write lock.
module lcd_cmd_sequencer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             host_cmd,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic                   lcd_busy,
    input  logic                   lcd_done,
    output logic [3:0]             lcd_cmd,
    output logic                   lcd_cmd_valid,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   err_illegal,
    output logic                   seq_done
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];
    localparam logic [3:0]  GAP_LOAD   = GAP_CYCLES[3:0];

    typedef enum logic [2:0] {
        LOAD_WAIT,
        IDLE,
        GAP,
        WAIT_DONE,
        FINISHED
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    gap_cnt, gap_cnt_nxt;
    logic [3:0]    head;
    logic          write_accepted;
    logic          fifo_full, fifo_empty;
    logic          accept, legal, push, pop;

    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);
    assign host_ready = !fifo_full && !write_accepted && (state != FINISHED);
    assign legal      = (host_cmd < 4'd12);
    assign accept     = host_valid && host_ready;
    assign push       = accept && legal;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOAD_WAIT;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        pop         = 1'b0;
        case (state)
            LOAD_WAIT: begin
                if (!lcd_busy) state_nxt = IDLE;
            end
            IDLE: begin
                if (!fifo_empty && !lcd_busy) begin
                    pop = 1'b1;
                    if (head == 4'd0) begin
                        state_nxt = WAIT_DONE;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GAP_LOAD;
                    end
                end
            end
            // Counter is checked before decrementing, so GAP always lasts GAP_CYCLES+1 cycles.
            GAP: begin
                if (gap_cnt == '0) state_nxt = IDLE;
                else               gap_cnt_nxt = gap_cnt - 4'd1;
            end
            WAIT_DONE: begin
                if (lcd_done) state_nxt = FINISHED;
            end
            FINISHED: state_nxt = FINISHED;
            default:  state_nxt = LOAD_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host_cmd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            write_accepted <= 1'b0;
            lcd_cmd        <= '0;
            lcd_cmd_valid  <= 1'b0;
            err_illegal    <= 1'b0;
            seq_done       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push && host_cmd == 4'd0) write_accepted <= 1'b1;
            lcd_cmd_valid <= pop;
            if (pop) lcd_cmd <= head;
            err_illegal <= accept && !legal;
            if (state == WAIT_DONE && lcd_done) seq_done <= 1'b1;
        end
    end
endmodule
